// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed DIGITS-wide 7-segment display driver with a refresh
// prescaler, per-slot anti-ghost blanking, frame-synchronous double buffering,
// leading-zero blanking and optional hex glyphs.
module seg7_scan_driver #(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned PRESCALE       = 50000,
   parameter int unsigned BLANK_CYCLES   = 16,
   parameter int unsigned HEX_MODE       = 0,
   parameter int unsigned SEG_ACTIVE_LOW = 1,
   parameter int unsigned DIG_ACTIVE_LOW = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [4*DIGITS-1:0] value,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic                load,
   input  logic                blank_lz,
   output logic [6:0]          seg,
   output logic                dp,
   output logic [DIGITS-1:0]   dig,
   output logic                frame_tick
);

   localparam int unsigned PcW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [PcW-1:0]  PcMax  = PcW'(PRESCALE - 1);
   localparam logic [PcW-1:0]  PcShow = PcW'(BLANK_CYCLES);
   localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);

   // Dark (inactive) levels of the output lines
   localparam logic [6:0]        SegOff = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic              DpOff  = (SEG_ACTIVE_LOW != 0);
   localparam logic [DIGITS-1:0] DigOff = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

   logic [PcW-1:0]      pc_d, pc_q;
   logic [IdxW-1:0]     idx_d, idx_q;
   logic                pend_d, pend_q;
   logic [4*DIGITS-1:0] pend_val_d, pend_val_q;
   logic [DIGITS-1:0]   pend_dp_d, pend_dp_q;
   logic [4*DIGITS-1:0] shadow_val_d, shadow_val_q;
   logic [DIGITS-1:0]   shadow_dp_d, shadow_dp_q;
   logic [6:0]          seg_d, seg_q;
   logic                dp_d, dp_q;
   logic [DIGITS-1:0]   dig_d, dig_q;
   logic                frame_tick_d, frame_tick_q;
   logic                slot_end, frame_wrap;

   // Logical abcdefg glyph, active-high; 10-15 blank unless hex glyphs are enabled
   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'b1111110;
         4'h1:    g = 7'b0110000;
         4'h2:    g = 7'b1101101;
         4'h3:    g = 7'b1111001;
         4'h4:    g = 7'b0110011;
         4'h5:    g = 7'b1011011;
         4'h6:    g = 7'b1011111;
         4'h7:    g = 7'b1110000;
         4'h8:    g = 7'b1111111;
         4'h9:    g = 7'b1111011;
         4'hA:    g = 7'b1110111;
         4'hB:    g = 7'b0011111;
         4'hC:    g = 7'b1001110;
         4'hD:    g = 7'b0111101;
         4'hE:    g = 7'b1001111;
         default: g = 7'b1000111;
      endcase
      if ((HEX_MODE == 0) && (nib > 4'h9)) begin
         g = 7'b0000000;
      end
      return g;
   endfunction

   // Prescaler and scan counter; both freeze while enable is low
   always_comb begin
      slot_end   = enable && (pc_q == PcMax);
      frame_wrap = slot_end && (idx_q == IdxMax);
      pc_d       = pc_q;
      idx_d      = idx_q;
      if (enable) begin
         if (slot_end) begin
            pc_d  = '0;
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
         end else begin
            pc_d = pc_q + 1'b1;
         end
      end
   end

   // Double buffer: loads park in pending and move to shadow only at the frame wrap,
   // except when the display is stopped or the load lands on the wrap itself
   always_comb begin
      pend_d       = pend_q;
      pend_val_d   = pend_val_q;
      pend_dp_d    = pend_dp_q;
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      if (load && (!enable || frame_wrap)) begin
         shadow_val_d = value;
         shadow_dp_d  = dp_in;
         pend_d       = 1'b0;
      end else if (load) begin
         pend_val_d = value;
         pend_dp_d  = dp_in;
         pend_d     = 1'b1;
      end else if (frame_wrap && pend_q) begin
         shadow_val_d = pend_val_q;
         shadow_dp_d  = pend_dp_q;
         pend_d       = 1'b0;
      end
   end

   // Output decode for the current slot, registered one cycle later
   always_comb begin
      logic [3:0]        nib;
      logic              cur_dp;
      logic              upper_zero;
      logic              lz_blank;
      logic [DIGITS-1:0] sel;
      logic [6:0]        glyph_bits;
      nib          = 4'h0;
      cur_dp       = 1'b0;
      upper_zero   = 1'b1;
      lz_blank     = 1'b0;
      sel          = '0;
      glyph_bits   = 7'b0;
      seg_d        = SegOff;
      dp_d         = DpOff;
      dig_d        = DigOff;
      frame_tick_d = frame_wrap;
      // Walk from the most significant digit so upper_zero covers DIGITS-1..i
      for (int i = DIGITS - 1; i >= 0; i--) begin
         upper_zero = upper_zero && (shadow_val_q[4*i +: 4] == 4'h0);
         if (IdxW'(i) == idx_q) begin
            nib      = shadow_val_q[4*i +: 4];
            cur_dp   = shadow_dp_q[i];
            lz_blank = upper_zero && (i != 0);
            sel[i]   = 1'b1;
         end
      end
      glyph_bits = (blank_lz && lz_blank) ? 7'b0 : glyph(nib);
      if (enable) begin
         seg_d = (SEG_ACTIVE_LOW != 0) ? ~glyph_bits : glyph_bits;
         dp_d  = (SEG_ACTIVE_LOW != 0) ? ~cur_dp : cur_dp;
         if (pc_q >= PcShow) begin
            dig_d = (DIG_ACTIVE_LOW != 0) ? ~sel : sel;
         end
      end
   end

   // Counter and buffer state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q         <= '0;
         idx_q        <= '0;
         pend_q       <= 1'b0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
      end else begin
         pc_q         <= pc_d;
         idx_q        <= idx_d;
         pend_q       <= pend_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
      end
   end

   // Output registers, reset to the dark level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q        <= SegOff;
         dp_q         <= DpOff;
         dig_q        <= DigOff;
         frame_tick_q <= 1'b0;
      end else begin
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         dig_q        <= dig_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign dig        = dig_q;
   assign frame_tick = frame_tick_q;

endmodule
